// File: rtl/alu_issue_pkg.sv
// Shared encodings and the issue payload for the RV32I integer decode/issue stage.
// The ALU opcode is {1'b0, imm, funct3, alt}.
package alu_issue_pkg;

  localparam logic [6:0] RV_OP     = 7'b0110011;
  localparam logic [6:0] RV_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV_LUI    = 7'b0110111;
  localparam logic [6:0] RV_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [5:0] ALU_ADD  = 6'h00;
  localparam logic [5:0] ALU_SUB  = 6'h01;
  localparam logic [5:0] ALU_SLL  = 6'h02;
  localparam logic [5:0] ALU_SLT  = 6'h04;
  localparam logic [5:0] ALU_SLTU = 6'h06;
  localparam logic [5:0] ALU_XOR  = 6'h08;
  localparam logic [5:0] ALU_SRL  = 6'h0A;
  localparam logic [5:0] ALU_SRA  = 6'h0B;
  localparam logic [5:0] ALU_OR   = 6'h0C;
  localparam logic [5:0] ALU_AND  = 6'h0E;
  localparam int         ALU_IMM_BIT = 4;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } alu_issue_t;

  localparam int ALU_ISSUE_W = $bits(alu_issue_t);

  function automatic logic [5:0] alu_op(input logic [2:0] funct3, input logic alt, input logic imm);
    logic [5:0] op;
    op = {2'b00, funct3, alt};
    op[ALU_IMM_BIT] = imm;
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Instruction-in / ALU-issue-out handshake bundle for the decode/issue stage.
// slave is the decoder's view, master is the producer/consumer side.
interface alu_issue_decoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;

  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
    input  in_ready,
    input  out_valid, out_opcode, out_a, out_b, out_rd, out_illegal,
    output out_ready
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
    output in_ready,
    output out_valid, out_opcode, out_a, out_b, out_rd, out_illegal,
    input  out_ready
  );

endinterface

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer: output always shows main, skid absorbs one accept while main stalls.
// in_ready is simply !skid_valid, so both handshake sides come straight from flops.
module alu_issue_skid #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         drain;

  assign accept    = in_valid & ~skid_valid;
  assign drain     = main_valid & out_ready;
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      // skid can only be occupied while in_ready is low, so accept and skid never coincide here
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into ALU opcode + operands, issued through a skid buffer.
// Illegal encodings issue in order with zeroed fields; counters move on the output handshake.
module alu_issue_decoder
  import alu_issue_pkg::*;
#(
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  alu_issue_decoder_if.slave   bus,
  output logic [31:0]          issue_count,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  logic [6:0] major;
  funct3_e    funct3;
  logic [6:0] funct7;
  logic       legal;
  alu_issue_t dec;
  alu_issue_t held;
  logic       held_valid;
  logic       out_fire;

  assign major  = bus.in_instr[6:0];
  assign funct3 = funct3_e'(bus.in_instr[14:12]);
  assign funct7 = bus.in_instr[31:25];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    unique case (major)
      RV_OP: begin
        legal      = (funct7 == F7_ZERO) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        dec.opcode = alu_op(funct3, bus.in_instr[30], 1'b0);
        dec.a      = bus.in_rs1_data;
        dec.b      = bus.in_rs2_data;
      end
      RV_OP_IMM: begin
        dec.a = bus.in_rs1_data;
        if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
          // shamt lives in imm[4:0]; imm[11:5] acts as funct7 and selects srai
          legal      = (funct7 == F7_ZERO) || ((funct7 == F7_ALT) && (funct3 == F3_SR));
          dec.opcode = alu_op(funct3, funct7 == F7_ALT, 1'b1);
          dec.b      = {27'b0, bus.in_instr[24:20]};
        end else begin
          legal      = 1'b1;
          dec.opcode = alu_op(funct3, 1'b0, 1'b1);
          dec.b      = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        end
      end
      RV_LUI: begin
        legal      = 1'b1;
        dec.opcode = alu_op(F3_ADD, 1'b0, 1'b1);
        dec.b      = {bus.in_instr[31:12], 12'b0};
      end
      RV_AUIPC: begin
        legal      = 1'b1;
        dec.opcode = alu_op(F3_ADD, 1'b0, 1'b1);
        dec.a      = bus.in_pc;
        dec.b      = {bus.in_instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    dec.rd = bus.in_instr[11:7];
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  alu_issue_skid #(
    .W(ALU_ISSUE_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec),
    .out_valid (held_valid),
    .out_ready (bus.out_ready),
    .out_data  (held)
  );

  assign bus.out_valid   = held_valid;
  assign bus.out_opcode  = held.opcode;
  assign bus.out_a       = held.a;
  assign bus.out_b       = held.b;
  assign bus.out_rd      = held.rd;
  assign bus.out_illegal = held.illegal;

  assign out_fire = held_valid & bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_count   <= '0;
      illegal_count <= '0;
    end else if (out_fire) begin
      if (held.illegal) begin
        if (illegal_count != {ILL_CNT_W{1'b1}}) begin
          illegal_count <= illegal_count + ILL_CNT_W'(1);
        end
      end else begin
        issue_count <= issue_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: directed decode cases, backpressure, flush, reset and a random stream
// scored against an instruction-level reference model and a queue of buffered entries.
module tb_alu_issue_decoder;

  localparam int ILL_W   = 3;
  localparam int ILL_MAX = 7;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic [31:0]       issue_count;
  logic [ILL_W-1:0]  illegal_count;

  alu_issue_decoder_if bus();

  alu_issue_decoder #(
    .ILL_CNT_W(ILL_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .issue_count   (issue_count),
    .illegal_count (illegal_count)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned m_issue = 0;
  int          m_ill = 0;
  exp_t        q[$];

  // Reference decode built from the instruction-set rules with plain arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   f3, f7, opc;
    bit   ok;
    e   = '0;
    ok  = 1;
    f3  = int'((ins >> 12) & 32'd7);
    f7  = int'(ins >> 25);
    opc = int'(ins & 32'h7F);
    e.rd = ins[11:7];
    case (opc)
      'h33: begin
        e.a = r1; e.b = r2;
        if (f7 == 0) e.op = 6'(2 * f3);
        else if (f7 == 32 && (f3 == 0 || f3 == 5)) e.op = 6'(2 * f3 + 1);
        else ok = 0;
      end
      'h13: begin
        e.a = r1;
        if (f3 == 1 || f3 == 5) begin
          e.b = (ins >> 20) & 32'd31;
          if (f7 == 0) e.op = 6'(16 + 2 * f3);
          else if (f7 == 32 && f3 == 5) e.op = 6'(16 + 2 * f3 + 1);
          else ok = 0;
        end else begin
          e.b  = 32'($signed(ins) >>> 20);
          e.op = 6'(16 + 2 * f3);
        end
      end
      'h37: begin e.a = 0;  e.b = ins & 32'hFFFFF000; e.op = 6'd16; end
      'h17: begin e.a = pc; e.b = ins & 32'hFFFFF000; e.op = 6'd16; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0, 1: w[6:0] = 7'h33;
      2:    w[6:0] = 7'h13;
      3:    w[6:0] = 7'h37;
      4:    w[6:0] = 7'h17;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  function automatic exp_t observed();
    return {bus.out_opcode, bus.out_a, bus.out_b, bus.out_rd, bus.out_illegal};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid    = v;
    bus.in_instr    = ins;
    bus.in_pc       = pc;
    bus.in_rs1_data = r1;
    bus.in_rs2_data = r2;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= ILL_MAX) ? ILL_MAX : v + 1;
  endfunction

  task automatic test_reset();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_chk++; if (observed() !== exp_t'(0)) $display("FAIL reset_fields got %h want 0", observed()); else n_pass++;
    n_chk++; if (issue_count !== 32'd0) $display("FAIL reset_issue_count got %0d want 0", issue_count); else n_pass++;
    n_chk++; if (illegal_count !== '0) $display("FAIL reset_illegal_count got %0d want 0", illegal_count); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] ins, pc, r1, r2;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      pc = 32'h0; r1 = 32'hDEAD; r2 = 32'hBEEF;
      case (i)
        0: begin ins = 32'h002081B3; r1 = 5;  r2 = 7; e = '{6'h00, 32'd5, 32'd7, 5'd3, 1'b0}; end
        1: begin ins = 32'h40208133; r1 = 20; r2 = 7; e = '{6'h01, 32'd20, 32'd7, 5'd2, 1'b0}; end
        2: begin ins = 32'h4030D293; r1 = 32'h80000000; e = '{6'h1B, 32'h80000000, 32'd3, 5'd5, 1'b0}; end
        3: begin ins = 32'hFFF08093; r1 = 10; e = '{6'h10, 32'd10, 32'hFFFFFFFF, 5'd1, 1'b0}; end
        4: begin ins = 32'h123453B7; e = '{6'h10, 32'd0, 32'h12345000, 5'd7, 1'b0}; end
        5: begin ins = 32'h12345397; pc = 32'h100; e = '{6'h10, 32'h100, 32'h12345000, 5'd7, 1'b0}; end
        6: begin ins = 32'h022080B3; e = '{6'h00, 32'd0, 32'd0, 5'd0, 1'b1}; end
        7: begin ins = 32'h402091B3; e = '{6'h00, 32'd0, 32'd0, 5'd0, 1'b1}; end
        default: begin ins = 32'h00002083; e = '{6'h00, 32'd0, 32'd0, 5'd0, 1'b1}; end
      endcase
      set_in(1'b1, ins, pc, r1, r2);
      bus.out_ready = 1'b0;
      step();
      set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL decode%0d_latency out_valid got %b want 1", i, bus.out_valid); else n_pass++;
      n_chk++; if (observed() !== e) $display("FAIL decode%0d_fields got %h want %h", i, observed(), e); else n_pass++;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      if (e.ill) m_ill = sat_inc(m_ill); else m_issue++;
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL decode%0d_drain out_valid got %b want 0", i, bus.out_valid); else n_pass++;
      n_chk++; if (issue_count !== m_issue) $display("FAIL decode%0d_issue_count got %0d want %0d", i, issue_count, m_issue); else n_pass++;
      n_chk++; if (illegal_count !== ILL_W'(m_ill)) $display("FAIL decode%0d_illegal_count got %0d want %0d", i, illegal_count, m_ill); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    exp_t ea, eb, ec;
    ea = '{6'h00, 32'd11, 32'd22, 5'd3, 1'b0};
    eb = '{6'h00, 32'd33, 32'd44, 5'd4, 1'b0};
    ec = '{6'h00, 32'd55, 32'd66, 5'd5, 1'b0};
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd11, 32'd22);
    step();
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL bp_first_in_ready got %b want 1", bus.in_ready); else n_pass++;
    set_in(1'b1, 32'h00208233, 32'h0, 32'd33, 32'd44);
    step();
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_drop got %b want 0", bus.in_ready); else n_pass++;
    set_in(1'b1, 32'h002082B3, 32'h0, 32'd55, 32'd66);
    repeat (2) begin
      step();
      n_chk++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL bp_stall in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid); else n_pass++;
      n_chk++; if (observed() !== ea) $display("FAIL bp_hold got %h want %h", observed(), ea); else n_pass++;
    end
    bus.out_ready = 1'b1;
    step();
    m_issue++;
    n_chk++; if (observed() !== eb || bus.in_ready !== 1'b1) $display("FAIL bp_second got %h rdy %b want %h rdy 1", observed(), bus.in_ready, eb); else n_pass++;
    step();
    m_issue++;
    n_chk++; if (observed() !== ec || bus.out_valid !== 1'b1) $display("FAIL bp_third got %h vld %b want %h vld 1", observed(), bus.out_valid, ec); else n_pass++;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    m_issue++;
    bus.out_ready = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_chk++; if (issue_count !== m_issue) $display("FAIL bp_issue_count got %0d want %0d", issue_count, m_issue); else n_pass++;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    set_in(1'b1, 32'h022080B3, 32'h0, 32'd1, 32'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) $display("FAIL sat_stream%0d in_ready=%b out_valid=%b want 1/1", i, bus.in_ready, bus.out_valid); else n_pass++;
    end
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) m_ill = sat_inc(m_ill);
    n_chk++; if (illegal_count !== ILL_W'(m_ill)) $display("FAIL sat_illegal_count got %0d want %0d", illegal_count, m_ill); else n_pass++;
    n_chk++; if (issue_count !== m_issue) $display("FAIL sat_issue_count got %0d want %0d", issue_count, m_issue); else n_pass++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
    step();
    step();
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL flush_full in_ready got %b want 0", bus.in_ready); else n_pass++;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL flush_full_after out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else n_pass++;
    n_chk++; if (issue_count !== m_issue) $display("FAIL flush_full_count got %0d want %0d", issue_count, m_issue); else n_pass++;
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd3, 32'd4);
    step();
    set_in(1'b1, 32'h00208233, 32'h0, 32'd5, 32'd6);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    m_issue++;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL flush_hs out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else n_pass++;
    n_chk++; if (issue_count !== m_issue) $display("FAIL flush_hs_count got %0d want %0d", issue_count, m_issue); else n_pass++;
    step();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL flush_discard out_valid got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd7, 32'd8);
    step();
    step();
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL arst_full in_ready got %b want 0", bus.in_ready); else n_pass++;
    #3;
    reset = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL arst_async out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else n_pass++;
    n_chk++; if (issue_count !== 32'd0 || illegal_count !== '0) $display("FAIL arst_counters issue=%0d illegal=%0d want 0/0", issue_count, illegal_count); else n_pass++;
    step();
    reset = 1'b1;
    m_issue = 0;
    m_ill = 0;
    step();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL arst_release out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ins, pc, r1, r2;
    logic v, rdy, acc, drn;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      n_chk++; if (bus.out_valid !== (q.size() > 0)) $display("FAIL rand%0d_out_valid got %b want %b", c, bus.out_valid, q.size() > 0); else n_pass++;
      n_chk++; if (bus.in_ready !== (q.size() < 2)) $display("FAIL rand%0d_in_ready got %b want %b", c, bus.in_ready, q.size() < 2); else n_pass++;
      if (q.size() > 0) begin
        n_chk++; if (observed() !== q[0]) $display("FAIL rand%0d_fields got %h want %h", c, observed(), q[0]); else n_pass++;
      end
      n_chk++;
      if (issue_count !== m_issue || illegal_count !== ILL_W'(m_ill))
        $display("FAIL rand%0d_counters issue=%0d illegal=%0d want %0d/%0d", c, issue_count, illegal_count, m_issue, m_ill);
      else n_pass++;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      ins = rand_instr();
      pc  = $urandom;
      r1  = $urandom;
      r2  = $urandom;
      set_in(v, ins, pc, r1, r2);
      bus.out_ready = rdy;
      acc = v && (q.size() < 2);
      drn = rdy && (q.size() > 0);
      if (drn) begin
        if (q[0].ill) m_ill = sat_inc(m_ill); else m_issue++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_decode(ins, pc, r1, r2));
      step();
    end
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_saturation();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
